// File: rtl/sw_pkg.sv
// Shared constants for the stopwatch time counter: nibble width, digit limits
// and the position of each digit inside the packed 16-bit time word.
package sw_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;

  localparam int IDX_HUND     = 0;
  localparam int IDX_TENTHS   = 1;
  localparam int IDX_SEC_ONES = 2;
  localparam int IDX_SEC_TENS = 3;

  localparam int HUND_MAX     = 9;
  localparam int TENTHS_MAX   = 9;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;

  function automatic int digit_max(input int idx);
    case (idx)
      IDX_HUND:     return HUND_MAX;
      IDX_TENTHS:   return TENTHS_MAX;
      IDX_SEC_ONES: return SEC_ONES_MAX;
      default:      return SEC_TENS_MAX;
    endcase
  endfunction

endpackage

// File: rtl/sw_time_counter_bcd_digit.sv
// One BCD digit of the time cascade: counts 0..MAX when enabled and raises
// carry_out in the cycle it wraps back to 0.
module bcd_digit
  import sw_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);

  logic at_max;

  assign at_max    = (value == BCD_W'(MAX));
  assign carry_out = enable && at_max;

  // NOTE: state registers use non-blocking assignments so every digit in the
  // cascade samples its neighbours' pre-edge values on the same clock.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (enable) begin
      value <= at_max ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/sw_time_counter.sv
// Stopwatch time counter (SS.hh in BCD) with a tick prescaler; optional lap
// freeze of the display value is enabled by defining SW_LAP_LATCH_EN.
module sw_time_counter
  import sw_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned TICK_HZ     = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init_regs,
  input  logic                        count_enabled,
  input  logic                        lap,
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic [NUM_DIGITS*BCD_W-1:0] disp_digits,
  output logic                        wrap,
  output logic                        frozen
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int          PRE_W = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("sw_time_counter: CLK_FREQ_HZ/TICK_HZ must be at least 2");
  end

  logic [PRE_W-1:0]    pre_cnt;
  logic                advance;
  logic                tick;
  logic [NUM_DIGITS:0] carry;

  assign advance = count_enabled && !init_regs;
  assign tick    = advance && (pre_cnt == PRE_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || init_regs) begin
      pre_cnt <= '0;
    end else if (advance) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  // The tick ripples through the digits as a combinational carry chain so
  // the whole time word updates on the tick edge.
  assign carry[0] = tick;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit #(
      .MAX(digit_max(i))
    ) u_digit (
      .clk      (clk),
      .reset    (reset),
      .enable   (carry[i]),
      .clear    (init_regs),
      .value    (digits[i*BCD_W +: BCD_W]),
      .carry_out(carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= carry[NUM_DIGITS];
    end
  end

`ifdef SW_LAP_LATCH_EN
  logic [NUM_DIGITS*BCD_W-1:0] lap_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      frozen    <= 1'b0;
      lap_value <= '0;
    end else if (init_regs) begin
      frozen <= 1'b0;
    end else if (lap) begin
      if (frozen) begin
        frozen <= 1'b0;
      end else begin
        frozen    <= 1'b1;
        lap_value <= digits;
      end
    end
  end

  // Output mux selects between two registers only, so no input reaches it.
  assign disp_digits = frozen ? lap_value : digits;
`else
  logic lap_unused;

  assign lap_unused  = lap;
  assign frozen      = 1'b0;
  assign disp_digits = digits;
`endif

endmodule

// File: doc/sw_time_counter.md
SW_TIME_COUNTER -- requirements
Module: sw_time_counter

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count resolution in Hz (one hundredth of a second).
REQ-003 SHALL have port clk, input, 1, system clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port init_regs, input, 1, level; clears the time value while high.
REQ-006 SHALL have port count_enabled, input, 1, level; advances time while high.
REQ-007 SHALL have port lap, input, 1, single-cycle pulse; toggles display freeze.
REQ-008 SHALL have port digits, output, 16, live BCD time {sec_tens, sec_ones, tenths, hundredths}, 4 bits each, MSB first.
REQ-009 SHALL have port disp_digits, output, 16, BCD value intended for the display, same layout as digits.
REQ-010 SHALL have port wrap, output, 1, one-cycle pulse on rollover from 59.99 to 00.00.
REQ-011 SHALL have port frozen, output, 1, high while disp_digits is held.

Function
REQ-012 SHALL use a prescaler counter running 0..DIV-1, where DIV = CLK_FREQ_HZ/TICK_HZ, with width $clog2(DIV).
REQ-013 SHALL have the prescaler advance only when count_enabled=1 and init_regs=0.
REQ-014 SHALL generate an internal tick when the prescaler is at DIV-1 and advances; the prescaler returns to 0 on the same edge.
REQ-015 SHALL increment digits on the same edge as the tick, so the new value is visible in the cycle after the prescaler reaches DIV-1.
REQ-016 SHALL cascade the digits as follows: hundredths 0..9, tenths 0..9, sec_ones 0..9, sec_tens 0..5; each carries into the next digit on wrap to 0.
REQ-017 SHALL, on a tick at 59.99, set digits to 00.00 and assert wrap for exactly one cycle.
REQ-018 SHALL, while count_enabled=0, hold the prescaler and digits unchanged; a partial tick is preserved across a pause.
REQ-019 SHALL, when init_regs=1, clear the prescaler and digits to 0 on the next edge, with priority over count_enabled; wrap stays 0.
REQ-020 SHALL register every output, with no combinational path from inputs to outputs.
REQ-021 SHALL never hold a non-BCD nibble (A..F) on digits; sec_tens never exceeds 5.

Reset
REQ-022 SHALL, on reset, clear the prescaler, digits, disp_digits, wrap and frozen to 0 on the next edge.
REQ-023 SHALL give reset priority over init_regs, count_enabled and lap.
REQ-024 SHALL recover from reset mid-count to 00.00 with no residual prescaler phase.

Configuration
REQ-025 SHALL gate the lap-freeze feature with macro SW_LAP_LATCH_EN.
REQ-026 SHALL, with SW_LAP_LATCH_EN defined, behave as follows:
- When frozen=0, a lap pulse captures the current digits into disp_digits and sets frozen=1.
- When frozen=1, a lap pulse clears frozen=0.
- While frozen=1, disp_digits holds and digits continue counting.
REQ-027 SHALL, with SW_LAP_LATCH_EN defined, make init_regs=1 clear frozen, with priority over a simultaneous lap pulse.
REQ-028 SHALL, with SW_LAP_LATCH_EN undefined, ignore lap, tie frozen to 0, and have disp_digits equal digits every cycle.
REQ-029 SHALL, whenever frozen=0, make disp_digits equal digits in the same cycle.

Structure
REQ-030 SHALL place BCD_W=4, the digit limits (9, 9, 9, 5) and the digit index constants in shared package sw_pkg.
REQ-031 SHALL implement each digit as sub-module bcd_digit (parameter MAX; ports: enable/carry-in, clear, value, carry-out), instantiated four times.
REQ-032 SHALL compute DIV at elaboration time; DIV < 2 is an elaboration error.

Verification (bench: CLK_FREQ_HZ=1000, TICK_HZ=100, so DIV=10)
REQ-033 SHALL verify basic counting: reset, then count_enabled=1 for 100 cycles -> digits=16'h0010 (00.10); first digit change at cycle 10.
REQ-034 SHALL verify pause: run 15 cycles, count_enabled=0 for 50 cycles, then run 5 cycles -> digits=16'h0002; no change during the pause.
REQ-035 SHALL verify rollover: run 5999 ticks, then 1 more tick -> digits=16'h0000 with wrap high for exactly 1 cycle.
REQ-036 SHALL verify clear priority: init_regs=1 together with count_enabled=1 at 12.34 -> digits=0 next cycle and the prescaler restarts from 0.
REQ-037 SHALL verify lap (macro defined): lap at 00.50 and run 200 cycles -> disp_digits=16'h0050, digits=16'h0070, frozen=1; second lap -> disp_digits=digits.
REQ-038 SHALL verify reset mid-operation: reset=1 while frozen and counting -> all outputs 0 next edge; lap and init_regs asserted simultaneously are ignored.
